// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer sitting directly behind the UART receiver.
//   Every byte flagged by the receiver's one-cycle rx_done pulse goes into a
//   circular first-word-fall-through FIFO. The host drains it through a
//   valid/ready stream. The FIFO also reports its fill level, a watermark
//   flag and a sticky overrun flag.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   rx_data        byte from the receiver, qualified by rx_done
//   rx_done        one-cycle pulse: rx_data holds a new byte
//   m_data         head-of-FIFO byte (8'h00 while empty)
//   m_valid        FIFO non-empty
//   m_ready        consumer accepts m_data this cycle
//   flush          synchronous clear of the FIFO contents
//   overrun_clr    clears the sticky overrun flag
//   level          number of stored bytes, 0..DEPTH
//   watermark_hit  level >= WATERMARK
//   overrun        sticky: a byte was dropped because the FIFO was full

module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int WATERMARK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_done,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     flush,
    input  logic                     overrun_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     watermark_hit,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign pop   = m_valid & m_ready;
    // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
    assign push  = rx_done & (~full | pop);
    // flush discards a coincident byte without counting it as an overrun.
    assign drop  = rx_done & full & ~pop & ~flush;

    assign m_valid       = ~empty;
    assign m_data        = empty ? 8'h00 : mem[rd_ptr];
    assign watermark_hit = (level >= LW'(WATERMARK));

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // If a set and a clear arrive in the same cycle, the set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       flush;
    logic       overrun_clr;
    logic [4:0] level;
    logic       watermark_hit;
    logic       overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_rx_fifo #(.DEPTH(16), .WATERMARK(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .overrun_clr(overrun_clr), .level(level),
        .watermark_hit(watermark_hit), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; m_ready = 1'b0;
        flush = 1'b0; overrun_clr = 1'b0;
        #1;
        total_cnt++; if (level !== 5'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (m_data !== 8'h00) $display("FAIL reset_m_data got=%h exp=00", m_data); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else pass_cnt++;
        total_cnt++; if (watermark_hit !== 1'b0) $display("FAIL reset_wm got=%b exp=0", watermark_hit); else pass_cnt++;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        push_byte(8'hA5);
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", m_valid); else pass_cnt++;
        total_cnt++; if (m_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", m_data); else pass_cnt++;
        total_cnt++; if (level !== 5'd1) $display("FAIL single_level got=%0d exp=1", level); else pass_cnt++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_pop_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL single_pop_level got=%0d exp=0", level); else pass_cnt++;
        total_cnt++; if (m_data !== 8'h00) $display("FAIL single_pop_data got=%h exp=00", m_data); else pass_cnt++;
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(i));
            total_cnt++;
            if (watermark_hit !== ((i + 1) >= 8))
                $display("FAIL fill_wm lvl=%0d got=%b exp=%b", i + 1, watermark_hit, ((i + 1) >= 8));
            else pass_cnt++;
        end
        total_cnt++; if (level !== 5'd16) $display("FAIL fill_level got=%0d exp=16", level); else pass_cnt++;
        push_byte(8'hFF);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL fill_overrun got=%b exp=1", overrun); else pass_cnt++;
        total_cnt++; if (level !== 5'd16) $display("FAIL fill_ovr_level got=%0d exp=16", level); else pass_cnt++;
        total_cnt++; if (m_data !== 8'h00) $display("FAIL fill_hold_data got=%h exp=00", m_data); else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (m_data !== 8'(i)) $display("FAIL drain_data idx=%0d got=%h exp=%h", i, m_data, 8'(i));
            else pass_cnt++;
            tick();
        end
        m_ready = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", m_valid); else pass_cnt++;
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL fill_clr got=%b exp=0", overrun); else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d;
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        rx_data = 8'h77; rx_done = 1'b1; m_ready = 1'b1;
        tick();
        rx_done = 1'b0; m_ready = 1'b0;
        total_cnt++; if (level !== 5'd16) $display("FAIL fpp_level got=%0d exp=16", level); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL fpp_overrun got=%b exp=0", overrun); else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_d = (i == 15) ? 8'h77 : 8'h11 + 8'(i);
            total_cnt++;
            if (m_data !== exp_d) $display("FAIL fpp_drain idx=%0d got=%h exp=%h", i, m_data, exp_d);
            else pass_cnt++;
            tick();
        end
        m_ready = 1'b0;
        total_cnt++; if (level !== 5'd0) $display("FAIL fpp_end_level got=%0d exp=0", level); else pass_cnt++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        total_cnt++; if (level !== 5'd5) $display("FAIL flush_pre_level got=%0d exp=5", level); else pass_cnt++;
        flush = 1'b1; rx_data = 8'hEE; rx_done = 1'b1;
        tick();
        flush = 1'b0; rx_done = 1'b0;
        total_cnt++; if (level !== 5'd0) $display("FAIL flush_level got=%0d exp=0", level); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL flush_overrun got=%b exp=0", overrun); else pass_cnt++;
        push_byte(8'h3C);
        total_cnt++; if (m_data !== 8'h3C) $display("FAIL flush_push_data got=%h exp=3c", m_data); else pass_cnt++;
        total_cnt++; if (level !== 5'd1) $display("FAIL flush_push_level got=%0d exp=1", level); else pass_cnt++;
        m_ready = 1'b1; tick(); m_ready = 1'b0;
    endtask

    task automatic test_overrun_clr();
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        push_byte(8'hAA);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", overrun); else pass_cnt++;
        rx_data = 8'hBB; rx_done = 1'b1; overrun_clr = 1'b1;
        tick();
        rx_done = 1'b0; overrun_clr = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got=%b exp=1", overrun); else pass_cnt++;
        total_cnt++; if (m_data !== 8'h80) $display("FAIL ovr_head got=%h exp=80", m_data); else pass_cnt++;
        flush = 1'b1; tick(); flush = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flush_keeps got=%b exp=1", overrun); else pass_cnt++;
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr got=%b exp=0", overrun); else pass_cnt++;
    endtask

    task automatic test_reset_and_wrap();
        logic [7:0] q[$];
        logic [7:0] d;
        for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i));
        for (int i = 0; i < 8; i++) push_byte(8'hD0 + 8'(i));
        total_cnt++; if (overrun !== 1'b1) $display("FAIL rst_pre_overrun got=%b exp=1", overrun); else pass_cnt++;
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        m_ready = 1'b0;
        total_cnt++; if (level !== 5'd9) $display("FAIL rst_pre_level got=%0d exp=9", level); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (level !== 5'd0) $display("FAIL rst_async_level got=%0d exp=0", level); else pass_cnt++;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (watermark_hit !== 1'b0) $display("FAIL rst_async_wm got=%b exp=0", watermark_hit); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_async_overrun got=%b exp=0", overrun); else pass_cnt++;
        #1 rst = 1'b0;
        tick();
        // Fill to 15, then push/pop together for 40 cycles so the pointers
        // wrap repeatedly while the level sits at the full boundary.
        for (int i = 0; i < 15; i++) begin
            d = 8'h20 + 8'(i);
            push_byte(d);
            q.push_back(d);
        end
        push_byte(8'h2F);
        q.push_back(8'h2F);
        for (int i = 0; i < 40; i++) begin
            total_cnt++;
            if (m_data !== q[0]) $display("FAIL wrap_data cyc=%0d got=%h exp=%h", i, m_data, q[0]);
            else pass_cnt++;
            d = 8'h60 + 8'(i);
            rx_data = d; rx_done = 1'b1; m_ready = 1'b1;
            tick();
            void'(q.pop_front());
            q.push_back(d);
            total_cnt++;
            if (level !== 5'(q.size())) $display("FAIL wrap_level cyc=%0d got=%0d exp=%0d", i, level, q.size());
            else pass_cnt++;
        end
        rx_done = 1'b0;
        while (q.size() > 0) begin
            total_cnt++;
            if (m_data !== q[0]) $display("FAIL wrap_drain got=%h exp=%h", m_data, q[0]);
            else pass_cnt++;
            tick();
            void'(q.pop_front());
        end
        m_ready = 1'b0;
        total_cnt++; if (m_valid !== 1'b0) $display("FAIL wrap_end_valid got=%b exp=0", m_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL wrap_overrun got=%b exp=0", overrun); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overrun();
        test_full_push_pop();
        test_flush();
        test_overrun_clr();
        test_reset_and_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
